uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL declare its ports in the positional order rst_n, clk, rx, ready, error, val.
REQ-002 Parameter CLK_FREQ, default 100000000, SHALL set the clk frequency in Hz.
REQ-003 Parameter BAUD, default 115200, SHALL set the line bit rate.
REQ-004 Derived CLKS_PER_BIT = CLK_FREQ/BAUD, integer division, SHALL be 868 at the defaults.
REQ-005 clk  input  1  SHALL be the single clock; all logic is on the rising edge.
REQ-006 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-007 rx  input  1  SHALL be the asynchronous serial line, idle high.
REQ-008 ready  output  1  SHALL be a one-cycle pulse marking a completed frame.
REQ-009 error  output  1  SHALL be the frame error flag, valid whenever ready is high.
REQ-010 val  output  8  SHALL carry the last received byte.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-012 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: a synchronized falling edge (1 then 0) SHALL load the bit counter and go to START.
REQ-014 START: at CLKS_PER_BIT/2 cycles (mid-bit), rx=0 SHALL go to DATA; rx=1 (glitch) SHALL return to IDLE with no ready and no error.
REQ-015 DATA: 8 bits SHALL be sampled, each CLKS_PER_BIT cycles after the previous sample, LSB first, into a shift register.
REQ-016 PARITY: one bit SHALL be sampled CLKS_PER_BIT after the last data bit and compared to even parity (XOR of the 8 data bits).
REQ-017 STOP: one bit SHALL be sampled CLKS_PER_BIT after the previous sample; rx=0 is a framing error.
REQ-018 In the cycle after the stop sample: val SHALL load the shift register, ready SHALL pulse high for exactly 1 cycle, error SHALL be (parity mismatch OR stop=0), and the FSM SHALL return to IDLE.
REQ-019 val and error SHALL hold their values until the next ready pulse.
REQ-020 On a framing error, return to IDLE SHALL still occur; a new start SHALL be recognised only after a 1-to-0 edge.
REQ-021 A falling edge during DATA, PARITY or STOP SHALL be ignored; sampling SHALL follow the timer only.
REQ-022 The baud timer SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at every sample point.

Reset
REQ-023 With rst_n=0 at a rising clk edge: state=IDLE, ready=0, error=0, val=8'h00, timer=0, bit counter=0, and synchronizer flops=1.
REQ-024 Reset asserted mid-frame SHALL abort the frame with no ready pulse; reception SHALL resume on the next falling edge after release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: the frame SHALL be 8E1 and the PARITY state SHALL be present as above.
REQ-026 Macro UART_RX_PARITY_EN undefined: the frame SHALL be 8N1, the PARITY state SHALL be skipped (STOP follows DATA), and error SHALL reflect only the stop bit.

Verification (defaults, 100 MHz clk, 8680 ns bits, UART_RX_PARITY_EN defined)
REQ-027 Reset, then rx idle 20 us, then start, data 1,0,1,0,1,0,0,1 (LSB first), parity 0, stop 1 -> one ready pulse, val=8'h95, error=0.
REQ-028 Send the REQ-027 frame 3 times back-to-back with 20 us idle between frames -> exactly 3 ready pulses, each with val=8'h95 and error=0.
REQ-029 Send 8'h95 with parity 1 -> ready pulse, val=8'h95, error=1; then send a good 8'h3C frame (parity 0) -> error=0.
REQ-030 Send 8'hA5 with stop bit 0, then return rx to 1 -> ready pulse with error=1; the next valid frame is received correctly.
REQ-031 Pulse rx low for 2 us while idle -> no ready pulse and the FSM is in IDLE.
REQ-032 Assert rst_n low during data bit 4, then release -> no ready pulse and val=8'h00; the next frame is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling-free UART receiver, 8 data bits LSB first, one stop bit.
// Ports: rst_n (sync, active low), clk, rx (async line, idle high),
//        ready (1-cycle frame-done pulse), error (frame/parity error), val (last byte).
// Define UART_RX_PARITY_EN for 8E1 frames (even parity checked); default is 8N1.
module uart_rx #(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 115200
) (
   input  logic       rst_n,
   input  logic       clk,
   input  logic       rx,
   output logic       ready,
   output logic       error,
   output logic [7:0] val
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int HALF_M1 = (HALF_BIT > 0) ? HALF_BIT - 1 : 0;

   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_M1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd3;
`endif
   localparam logic [2:0] STOP   = 3'd4;

   logic [2:0]    state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          rx_s1;
   logic          rx_s2;
   logic          rx_prev;
`ifdef UART_RX_PARITY_EN
   logic          par_err;
`endif

   logic fall;
   logic tick;

   // rx_prev trails the synchronized line so a start needs a real 1->0.
   assign fall = rx_prev & ~rx_s2;
   assign tick = (timer == BIT_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
         ready   <= 1'b0;
         error   <= 1'b0;
         val     <= 8'h00;
`ifdef UART_RX_PARITY_EN
         par_err <= 1'b0;
`endif
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
         ready   <= 1'b0;

         case (state)
            IDLE: begin
               timer <= '0;
               if (fall) begin
                  bit_cnt <= '0;
                  state   <= START;
               end
            end

            // Mid-bit recheck filters glitches shorter than half a bit.
            START: begin
               if (timer == HALF_LAST) begin
                  timer <= '0;
                  state <= rx_s2 ? IDLE : DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            DATA: begin
               if (tick) begin
                  timer   <= '0;
                  shift   <= {rx_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  timer   <= '0;
                  par_err <= (^shift) ^ rx_s2;
                  state   <= STOP;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
`endif

            STOP: begin
               if (tick) begin
                  timer <= '0;
                  ready <= 1'b1;
                  val   <= shift;
`ifdef UART_RX_PARITY_EN
                  error <= par_err | ~rx_s2;
`else
                  error <= ~rx_s2;
`endif
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               timer <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized + directed frames against a frame-level model.
// Scaled to 32 clocks per bit; honours UART_RX_PARITY_EN like the DUT.
module tb_uart_rx;

   localparam int CLK_FREQ = 32_000_000;
   localparam int BAUD     = 1_000_000;
   localparam int BIT_NS   = 320;
   localparam int IDLE_NS  = 2000;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx    = 1'b1;
   logic       ready;
   logic       error;
   logic [7:0] val;

   uart_rx #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .rst_n(rst_n),
      .clk  (clk),
      .rx   (rx),
      .ready(ready),
      .error(error),
      .val  (val)
   );

   always #5 clk = ~clk;

   int n_tests   = 0;
   int n_fail    = 0;
   int n_pulse   = 0;
   int exp_pulse = 0;

   // Expected completions, {error, byte}, oldest first.
   logic [8:0] exp_q[$];
   logic       ready_d = 1'b0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (ready_d)
         check("ready_width", 32'(ready), 32'd0);
      if (ready) begin
         n_pulse++;
         check("ready_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("val", 32'(val), 32'(e[7:0]));
            check("error", 32'(error), 32'(e[8]));
         end
      end
      ready_d <= ready;
   end

   // Drives one frame; abort_bit >= 0 resets the DUT midway through that data bit.
   task automatic send_frame(input logic [7:0] d,
                             input bit bad_par,
                             input bit bad_stop,
                             input int abort_bit);
      logic pbit;
      logic sbit;
      bit   err;
      pbit = logic'($countones(d) % 2) ^ bad_par;
      sbit = ~bad_stop;
`ifdef UART_RX_PARITY_EN
      err = ((($countones(d) + int'(pbit)) % 2) != 0) || !sbit;
`else
      err = !sbit;
`endif
      if (abort_bit < 0) begin
         exp_q.push_back({err, d});
         exp_pulse++;
      end
      rx = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         if (i == abort_bit) begin
            #(BIT_NS / 2);
            rx    = 1'b1;
            rst_n = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            return;
         end
         #(BIT_NS);
      end
`ifdef UART_RX_PARITY_EN
      rx = pbit;
      #(BIT_NS);
`endif
      rx = sbit;
      #(BIT_NS);
      if (!sbit) begin
         rx = 1'b1;
         #(BIT_NS);
      end
   endtask

   initial begin
      repeat (4) @(negedge clk);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_val", 32'(val), 32'h00);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #(IDLE_NS);

      // single good frame
      send_frame(8'h95, 1'b0, 1'b0, -1);
      #(IDLE_NS);
      check("pulses_single", 32'(n_pulse), 32'(exp_pulse));
      check("val_single", 32'(val), 32'h95);

      // three frames with idle gaps
      for (int k = 0; k < 3; k++) begin
         send_frame(8'h95, 1'b0, 1'b0, -1);
         #(IDLE_NS);
      end
      check("pulses_triple", 32'(n_pulse), 32'(exp_pulse));

      // bad parity then good frame
      send_frame(8'h95, 1'b1, 1'b0, -1);
      #(IDLE_NS);
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      #(IDLE_NS);
      check("pulses_parity", 32'(n_pulse), 32'(exp_pulse));

      // framing error then recovery
      send_frame(8'hA5, 1'b0, 1'b1, -1);
      #(IDLE_NS);
      send_frame(8'h5A, 1'b0, 1'b0, -1);
      #(IDLE_NS);
      check("pulses_frame", 32'(n_pulse), 32'(exp_pulse));

      // short glitch while idle
      rx = 1'b0;
      #80;
      rx = 1'b1;
      #(IDLE_NS);
      check("pulses_glitch", 32'(n_pulse), 32'(exp_pulse));
      send_frame(8'h11, 1'b0, 1'b0, -1);
      #(IDLE_NS);
      check("pulses_post_glitch", 32'(n_pulse), 32'(exp_pulse));

      // reset during data bit 4
      send_frame(8'h95, 1'b0, 1'b0, 4);
      #(IDLE_NS);
      check("pulses_abort", 32'(n_pulse), 32'(exp_pulse));
      check("val_abort", 32'(val), 32'h00);
      check("error_abort", 32'(error), 32'd0);
      send_frame(8'h95, 1'b0, 1'b0, -1);
      #(IDLE_NS);
      check("pulses_post_abort", 32'(n_pulse), 32'(exp_pulse));

      // randomized frames, gaps 0..3 bits
      for (int k = 0; k < 16; k++) begin
         send_frame(8'($urandom),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0),
                    -1);
         #($urandom_range(0, 3) * BIT_NS);
      end
      #(IDLE_NS);
      check("pulses_random", 32'(n_pulse), 32'(exp_pulse));
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
